// File: rtl/sop_lut_engine.sv
// sop_lut_engine: serially loaded 2^N-entry truth table with handshaked single
// evaluation and full-table sweep. Macro SOP_LUT_ONES_COUNT_EN builds the ones counter.
module sop_lut_engine #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_ready,
    input  logic         in_valid,
    input  logic [N-1:0] in_vec,
    output logic         in_ready,
    input  logic         sweep_start,
    output logic         out_valid,
    output logic         out_s,
    output logic [N-1:0] out_idx,
    input  logic         out_ready,
    output logic         sweep_done,
    output logic [N:0]   ones_count
);
    localparam int unsigned T        = 1 << N;
    localparam int unsigned CW       = N + 1;
    localparam logic [N-1:0] LAST_IDX = N'(T - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        SWEEP = 2'd3
    } state_e;

    state_e         state_q;
    logic [T-1:0]   table_q;
    logic [N-1:0]   load_cnt_q;
    logic [N-1:0]   load_cnt_d;
    logic           out_valid_q;
    logic           out_s_q;
    logic [N-1:0]   out_idx_q;
    logic [N-1:0]   sweep_idx_d;
    logic           sweep_done_q;
    logic           cfg_fire;
    logic           in_fire;
    logic           sweep_go;
    logic           out_fire;

    // Handshake qualifiers; RUN priority is cfg > sweep > eval.
    always_comb begin
        cfg_ready = 1'b0;
        case (state_q)
            EMPTY, LOAD: cfg_ready = 1'b1;
            RUN:         cfg_ready = !out_valid_q;
            default:     cfg_ready = 1'b0;
        endcase
        in_ready    = (state_q == RUN) && (!out_valid_q || out_ready)
                      && !cfg_valid && !sweep_start;
        cfg_fire    = cfg_valid && cfg_ready;
        in_fire     = in_valid && in_ready;
        sweep_go    = (state_q == RUN) && !out_valid_q && !cfg_valid && sweep_start;
        out_fire    = out_valid_q && out_ready;
        sweep_idx_d = out_idx_q + N'(1);
        load_cnt_d  = load_cnt_q + N'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            table_q      <= '0;
            load_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_s_q      <= 1'b0;
            out_idx_q    <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            case (state_q)
                EMPTY: begin
                    if (cfg_fire) begin
                        table_q[0] <= cfg_bit;
                        load_cnt_q <= N'(1);
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (cfg_fire) begin
                        table_q[load_cnt_q] <= cfg_bit;
                        if (load_cnt_q == LAST_IDX) begin
                            load_cnt_q <= '0;
                            state_q    <= RUN;
                        end else begin
                            load_cnt_q <= load_cnt_d;
                        end
                    end
                    if (out_fire) out_valid_q <= 1'b0;
                end
                RUN: begin
                    if (cfg_fire) begin
                        // A new load always restarts at minterm 0.
                        table_q[0] <= cfg_bit;
                        load_cnt_q <= N'(1);
                        state_q    <= LOAD;
                    end else if (sweep_go) begin
                        out_valid_q <= 1'b1;
                        out_idx_q   <= '0;
                        out_s_q     <= table_q[0];
                        state_q     <= SWEEP;
                    end else if (in_fire) begin
                        out_valid_q <= 1'b1;
                        out_idx_q   <= in_vec;
                        out_s_q     <= table_q[in_vec];
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (out_fire) begin
                        if (out_idx_q == LAST_IDX) begin
                            out_valid_q  <= 1'b0;
                            sweep_done_q <= 1'b1;
                            state_q      <= RUN;
                        end else begin
                            out_idx_q <= sweep_idx_d;
                            out_s_q   <= table_q[sweep_idx_d];
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef SOP_LUT_ONES_COUNT_EN
    logic [N:0] acc_q;
    logic [N:0] acc_d;
    logic [N:0] ones_q;

    assign acc_d = acc_q + CW'(out_s_q);

    // Accumulated count includes the final beat's bit when it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ones_q <= '0;
        end else if (sweep_go) begin
            acc_q <= '0;
        end else if ((state_q == SWEEP) && out_fire) begin
            acc_q <= acc_d;
            if (out_idx_q == LAST_IDX) ones_q <= acc_d;
        end
    end

    assign ones_count = ones_q;
`else
    assign ones_count = CW'(0);
`endif

    assign out_valid  = out_valid_q;
    assign out_s      = out_s_q;
    assign out_idx    = out_idx_q;
    assign sweep_done = sweep_done_q;

endmodule
